// File: rtl/hilbert_mac.sv
// hilbert_mac: 9-tap Hilbert FIR MAC over a rotating sample chain; emits analytic pair (re=x[n-4], im=FIR).
// Latency: enable sampled at edge T -> cnt_stop low T+1..T+9, one-cycle out_valid after edge T+10.
// Backpressure: none; enable while busy aborts the run and sets sticky overrun. Macro HILBERT_MAC_SAT_EN clamps im_out.
module hilbert_mac #(
  parameter int ORDER  = 8,    // only 8 is supported: tap/coefficient map below is fixed at 9 taps
  parameter int DATA_W = 16,
  parameter int COEF_W = 11,
  parameter int HA     = 245,  // |h1| = |h7|, Q1.10
  parameter int HB     = 641,  // |h3| = |h5|, Q1.10
  parameter int FRAC   = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] chain_in,
  output logic                     cnt_stop,
  output logic                     busy,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] re_out,
  output logic signed [DATA_W-1:0] im_out,
  output logic                     overrun
);

  localparam int TAPS   = ORDER + 1;
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int CENTRE = ORDER / 2;
  // 16s x 12s product; accumulator has headroom for four max-magnitude products
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + 2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TAPS);
  // Tap k is on chain_in while cnt == k+1
  localparam logic [CNT_W-1:0] CNT_H1  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_H3  = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_H5  = CNT_W'(6);
  localparam logic [CNT_W-1:0] CNT_H7  = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_CTR = CNT_W'(CENTRE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic signed [COEF_W:0] COEF_A = (COEF_W + 1)'(HA);
  localparam logic signed [COEF_W:0] COEF_B = (COEF_W + 1)'(HB);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [COEF_W:0]    coef;
  logic                      tap_nz;
  logic signed [PROD_W-1:0]  prod;
  logic signed [DATA_W-1:0]  re_hold;
  logic signed [DATA_W-1:0]  im_fmt;
  logic                      res_pend;  // final sum landed in acc; publish on the next edge

  // Chain rotates only while the counter is non-zero
  assign cnt_stop = (cnt == '0);
  assign busy     = ~cnt_stop;

  // Coefficient for the tap currently on chain_in: h = {0,-HA,0,-HB,0,+HB,0,+HA,0}
  always_comb begin
    coef   = '0;
    tap_nz = 1'b0;
    if (state == RUN) begin
      case (cnt)
        CNT_H1: begin coef = -COEF_A; tap_nz = 1'b1; end
        CNT_H3: begin coef = -COEF_B; tap_nz = 1'b1; end
        CNT_H5: begin coef =  COEF_B; tap_nz = 1'b1; end
        CNT_H7: begin coef =  COEF_A; tap_nz = 1'b1; end
        default: begin coef = '0; tap_nz = 1'b0; end
      endcase
    end
  end

  // Multiply only on the four non-zero taps; even taps contribute nothing
  always_comb begin
    prod = '0;
    if (tap_nz) begin
      prod = PROD_W'(chain_in) * PROD_W'(coef);
    end
  end

  assign acc_sum = acc + ACC_W'(prod);

`ifdef HILBERT_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (DATA_W - 1)));
  logic signed [ACC_W-1:0] acc_sh;

  // Floor-scale the sum back to sample units and clamp into the output range
  always_comb begin
    acc_sh = acc >>> FRAC;
    if (acc_sh > OUT_MAX) begin
      im_fmt = OUT_MAX[DATA_W-1:0];
    end else if (acc_sh < OUT_MIN) begin
      im_fmt = OUT_MIN[DATA_W-1:0];
    end else begin
      im_fmt = acc_sh[DATA_W-1:0];
    end
  end
`else
  // Floor-scale and keep the low bits: two's-complement wrap on overflow
  assign im_fmt = acc[FRAC +: DATA_W];
`endif

  // Tap sequencer, accumulator and registered result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      re_hold   <= '0;
      res_pend  <= 1'b0;
      out_valid <= 1'b0;
      re_out    <= '0;
      im_out    <= '0;
      overrun   <= 1'b0;
    end else begin
      // acc is read here before any restart below clears it
      out_valid <= res_pend;
      res_pend  <= 1'b0;
      if (res_pend) begin
        re_out <= re_hold;
        im_out <= im_fmt;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            cnt   <= CNT_LOAD;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            // Restart on the fresh sample; the interrupted result is dropped
            cnt     <= CNT_LOAD;
            acc     <= '0;
            overrun <= 1'b1;
          end else begin
            acc <= acc_sum;
            if (cnt == CNT_CTR) begin
              re_hold <= chain_in;
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNT_ONE) begin
              res_pend <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
